// File: rtl/riscv_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_lsu_pkg
// Description : Shared definitions for the RV32I load/store unit: funct3
//               width codes, FSM state encoding and the alignment legality
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_lsu_pkg;

    // RV32I funct3 codes; stores reuse the low three as sb/sh/sw
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // An access is legal when funct3 names a real width and the address is
    // naturally aligned to that width.
    function automatic logic access_legal(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~addr_lo[0];
            F3_W:        ok = (addr_lo == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_lsu_lane.sv
`default_nettype none
// ============================================================================
// Module      : riscv_lsu_lane
// Description : Byte-lane steering: byte enables and store-data replication
//               for the word bus, plus load extraction and extension.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_lsu_lane
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_rdata_i,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] load_data_o
);

    // Bring the addressed byte/halfword down to bit 0
    logic [31:0] w_shift;
    assign w_shift = mem_rdata_i >> {addr_lo_i, 3'b000};

    // Width is carried by funct3[1:0]; funct3[2] selects zero-extension
    always_comb begin
        mem_be_o    = 4'b1111;
        mem_wdata_o = wdata_i;
        load_data_o = mem_rdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                mem_be_o    = 4'b0001 << addr_lo_i;
                mem_wdata_o = {4{wdata_i[7:0]}};
                load_data_o = {{24{~funct3_i[2] & w_shift[7]}}, w_shift[7:0]};
            end
            2'b01: begin
                mem_be_o    = 4'b0011 << addr_lo_i;
                mem_wdata_o = {2{wdata_i[15:0]}};
                load_data_o = {{16{~funct3_i[2] & w_shift[15]}}, w_shift[15:0]};
            end
            default: begin
                mem_be_o    = 4'b1111;
                mem_wdata_o = wdata_i;
                load_data_o = mem_rdata_i;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : riscv_lsu
// Description : RV32I load/store unit. Latches one datapath request, runs a
//               single word-bus transfer with a bounded wait for mem_ack and
//               reports completion with a one-cycle done/err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_load;
    logic          w_access;

    riscv_lsu_lane u_lane (
        .funct3_i    (f3_q),
        .addr_lo_i   (addr_q[1:0]),
        .wdata_i     (wdata_q),
        .mem_rdata_i (mem_rdata),
        .mem_be_o    (w_be),
        .mem_wdata_o (w_wdata),
        .load_data_o (w_load)
    );

    // State and request registers; reset abandons any transfer in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state: accept in IDLE, wait for ack (ack wins on the last cycle)
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    f3_d    = funct3;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = '0;
                    if (access_legal(funct3, addr[1:0])) begin
                        state_d = ST_ACCESS;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = w_load;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus outputs are only non-zero while a transfer is outstanding
    assign w_access  = (state_q == ST_ACCESS);
    assign mem_req   = w_access;
    assign mem_we    = w_access & we_q;
    assign mem_addr  = w_access ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_be    = w_access ? w_be : 4'b0000;
    assign mem_wdata = w_access ? w_wdata : 32'd0;

    assign done  = (state_q == ST_RESP);
    assign err   = done & err_q;
    assign busy  = w_access | ((state_q == ST_IDLE) & req);
    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_lsu
// Description : Scoreboard bench for riscv_lsu with a reference model of the
//               load/store lane rules and a randomised memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_lsu;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;
    logic        busy, done, err;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    riscv_lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy),
        .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cycles;
    } bus_t;

    resp_t       exp_q[$];
    bus_t        bus_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rdata = 32'd0;

    // Responder controls (changed by the stimulus only around negedges)
    int          ack_delay = 0;
    logic [31:0] rdata_val = 32'd0;
    bit          manual_ack = 1'b0;
    logic        force_ack = 1'b0;
    int          resp_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit is_legal(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        return (a % size_of(f3)) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        int n;
        n = size_of(f3);
        v = rd >> (8 * (a % 4));
        if (n == 1) begin
            v = v % 256;
            if (f3 < 4 && v >= 128) v = v - 256;
        end else if (n == 2) begin
            v = v % 65536;
            if (f3 < 4 && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    // ---------------- memory responder ----------------
    always @(posedge clk) begin
        #1;
        if (manual_ack) begin
            resp_acc  = 0;
            mem_ack   = force_ack;
            mem_rdata = $urandom;
        end else if (mem_req) begin
            mem_ack   = (resp_acc == ack_delay);
            mem_rdata = rdata_val;
            resp_acc++;
        end else begin
            resp_acc  = 0;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
    end

    // ---------------- bus monitor ----------------
    bus_t cur;
    bit   active = 1'b0;
    bit   cur_ok = 1'b0;
    int   seen = 0;
    always @(negedge clk) begin
        if (mem_req) begin
            if (!active) begin
                active = 1'b1;
                seen   = 0;
                if (bus_q.size() == 0) begin
                    cur_ok = 1'b0;
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: mem_req=1 required 0 at %0t", $time);
                end else begin
                    cur_ok = 1'b1;
                    cur    = bus_q.pop_front();
                end
            end
            seen++;
            if (cur_ok) begin
                check("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
                check("mem_addr", mem_addr, cur.addr);
                check("mem_be", {28'd0, mem_be}, {28'd0, cur.be});
                if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
            end
        end else if (active) begin
            active = 1'b0;
            if (cur_ok) check("mem_req_cycles", seen, cur.cycles);
        end
    end

    // ---------------- response monitor ----------------
    logic  prev_done = 1'b0;
    resp_t r_exp;
    always @(negedge clk) begin
        check("err_without_done", {31'd0, err & ~done}, 32'd0);
        if (done) begin
            check("done_one_cycle", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: done=1 required 0 at %0t", $time);
            end else begin
                r_exp = exp_q.pop_front();
                check("err", {31'd0, err}, {31'd0, r_exp.err});
                check("rdata", rdata, r_exp.rdata);
            end
        end
        prev_done = done;
    end

    // ---------------- stimulus ----------------
    task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int dly, input logic [31:0] rd);
        int    n, k, exp_lat;
        bit    legal, acked, got;
        resp_t r;
        bus_t  b;
        n     = size_of(f3);
        legal = is_legal(f3, a);
        acked = legal && (dly < TIMEOUT);
        if (legal) begin
            b.we     = w;
            b.addr   = a & ~32'h3;
            b.be     = (n == 4) ? 4'hf : 4'(((1 << n) - 1) << (a % 4));
            b.wdata  = (n == 1) ? wd[7:0] * 32'h01010101 :
                       (n == 2) ? wd[15:0] * 32'h00010001 : wd;
            b.cycles = acked ? dly + 1 : TIMEOUT;
            bus_q.push_back(b);
        end
        if (acked && !w) model_rdata = ref_load(f3, a, rd);
        r.err   = !acked;
        r.rdata = model_rdata;
        exp_q.push_back(r);
        exp_lat   = !legal ? 1 : (acked ? dly + 2 : TIMEOUT + 1);
        ack_delay = dly;
        rdata_val = rd;

        @(posedge clk); #1;
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        check("busy_on_req", {31'd0, busy}, 32'd1);
        check("no_mem_req_cycle0", {31'd0, mem_req}, 32'd0);
        k = 0;
        got = 1'b0;
        while (!got && k < TIMEOUT + 10) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                req = 1'b0; we = 1'($urandom_range(0, 1)); funct3 = 3'($urandom_range(0, 7));
                addr = $urandom; wdata = $urandom;
            end
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                check("latency", k, exp_lat);
                check("busy_in_resp", {31'd0, busy}, 32'd0);
            end else begin
                check("busy_in_access", {31'd0, busy}, 32'd1);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles, required at cycle %0d", k, exp_lat);
        end
    endtask

    initial begin
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        int          dly;
        bus_t        b;

        rst = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b1;

        // directed cases
        run_txn(1'b0, 3'b010, 32'h8, 32'h0, 0, 32'hdeadc0de);            // lw
        run_txn(1'b0, 3'b000, 32'h7, 32'h0, 1, 32'h80123456);            // lb
        run_txn(1'b0, 3'b100, 32'h7, 32'h0, 2, 32'h80123456);            // lbu
        run_txn(1'b1, 3'b001, 32'h6, 32'h1234abcd, 3, 32'h0);            // sh
        run_txn(1'b0, 3'b010, 32'h5, 32'h0, 0, 32'h0);                   // misaligned lw
        run_txn(1'b0, 3'b111, 32'h0, 32'h0, 0, 32'h0);                   // bad funct3
        run_txn(1'b1, 3'b010, 32'h40, 32'hcafef00d, TIMEOUT + 3, 32'h0); // sw timeout
        run_txn(1'b0, 3'b101, 32'h102, 32'h0, TIMEOUT - 1, 32'h9abc5555); // lhu, last-cycle ack
        run_txn(1'b0, 3'b001, 32'h2, 32'h0, 0, 32'h8001ffff);            // lh negative

        // randomised sweep
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom_range(0, 1));
            if (w) begin
                case ($urandom_range(0, 7))
                    0, 1:    f3 = 3'd0;
                    2, 3:    f3 = 3'd1;
                    4, 5:    f3 = 3'd2;
                    6:       f3 = 3'd3;
                    default: f3 = 3'd7;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
                else if (f3[1:0] == 2'd1) a[0] = 1'b0;
            end
            dly = ($urandom_range(0, 7) == 0) ? TIMEOUT + $urandom_range(0, 3)
                                              : $urandom_range(0, 4);
            run_txn(w, f3, a, $urandom, dly, $urandom);
        end

        // make sure rdata is non-zero before the reset-abandon case
        run_txn(1'b0, 3'b010, 32'h20, 32'h0, 0, 32'h13579bdf);

        // reset in the second ACCESS cycle, ack arriving one cycle later
        manual_ack = 1'b1;
        force_ack  = 1'b0;
        b.we = 1'b0; b.addr = 32'h10; b.be = 4'hf; b.wdata = 32'h0; b.cycles = 2;
        bus_q.push_back(b);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        force_ack = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        model_rdata = 32'd0;
        @(negedge clk);
        force_ack = 1'b0;
        check("abandon_rdata", rdata, 32'd0);
        check("abandon_mem_req", {31'd0, mem_req}, 32'd0);
        check("abandon_mem_we", {31'd0, mem_we}, 32'd0);
        check("abandon_mem_addr", mem_addr, 32'd0);
        check("abandon_mem_be", {28'd0, mem_be}, 32'd0);
        check("abandon_mem_wdata", mem_wdata, 32'd0);
        check("abandon_done", {31'd0, done}, 32'd0);
        check("abandon_err", {31'd0, err}, 32'd0);
        check("abandon_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        manual_ack = 1'b0;

        // recovery after reset
        run_txn(1'b0, 3'b000, 32'h31, 32'h0, 1, 32'h00007f00);

        repeat (4) @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 32'd0);
        check("bus_queue_empty", bus_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
